// File: rtl/conv_scan_ctrl.sv
// Raster-scan sequencer: pops one frame of features from a FWFT buffer and
// presents them through a registered valid/ready stage tagged with position info.
module conv_scan_ctrl #(
   parameter int IMG_W  = 27,
   parameter int IMG_H  = 27,
   parameter int K      = 3,
   parameter int DATA_W = 8
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               start,
   output logic                                               busy,
   output logic                                               done,
   input  logic                                               feat_valid,
   input  logic [DATA_W-1:0]                                  feat_data,
   output logic                                               feat_rd_en,
   output logic                                               pix_valid,
   input  logic                                               pix_ready,
   output logic [DATA_W-1:0]                                  pix_data,
   output logic [$clog2(IMG_H)-1:0]                           pix_row,
   output logic [$clog2(IMG_W)-1:0]                           pix_col,
   output logic                                               win_valid,
   output logic                                               pix_last,
   output logic [$clog2((IMG_W-K+1)*(IMG_H-K+1)+1)-1:0]       win_count
);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int COL_W = $clog2(IMG_W);
   localparam int CNT_W = $clog2((IMG_W-K+1)*(IMG_H-K+1)+1);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H-1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W-1);
   localparam logic [ROW_W-1:0] WIN_ROW  = ROW_W'(K-1);
   localparam logic [COL_W-1:0] WIN_COL  = COL_W'(K-1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t            state_reg;
   logic [ROW_W-1:0]  rd_row_reg;
   logic [COL_W-1:0]  rd_col_reg;
   logic              issued_all_reg;
   logic              pop;
   logic              handshake;
   logic              rd_last;

   assign handshake = pix_valid & pix_ready;
   assign rd_last   = (rd_row_reg == LAST_ROW) && (rd_col_reg == LAST_COL);

   // A pop refills the output register, so it is allowed whenever that
   // register is empty or is being drained in the same cycle.
   assign pop        = (state_reg == S_STREAM) & feat_valid & (~pix_valid | pix_ready) & ~issued_all_reg;
   assign feat_rd_en = pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         rd_row_reg     <= '0;
         rd_col_reg     <= '0;
         issued_all_reg <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pix_valid      <= 1'b0;
         pix_data       <= '0;
         pix_row        <= '0;
         pix_col        <= '0;
         win_valid      <= 1'b0;
         pix_last       <= 1'b0;
         win_count      <= '0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_reg      <= S_STREAM;
                  busy           <= 1'b1;
                  rd_row_reg     <= '0;
                  rd_col_reg     <= '0;
                  issued_all_reg <= 1'b0;
                  win_count      <= '0;
               end
            end
            S_STREAM: begin
               if (pop) begin
                  pix_valid <= 1'b1;
                  pix_data  <= feat_data;
                  pix_row   <= rd_row_reg;
                  pix_col   <= rd_col_reg;
                  win_valid <= (rd_row_reg >= WIN_ROW) && (rd_col_reg >= WIN_COL);
                  pix_last  <= rd_last;
                  if (rd_last) begin
                     issued_all_reg <= 1'b1;
                  end
                  if (rd_col_reg == LAST_COL) begin
                     rd_col_reg <= '0;
                     rd_row_reg <= rd_row_reg + ROW_W'(1);
                  end else begin
                     rd_col_reg <= rd_col_reg + COL_W'(1);
                  end
               end else if (pix_ready) begin
                  pix_valid <= 1'b0;
               end
               if (handshake && win_valid) begin
                  win_count <= win_count + CNT_W'(1);
               end
               if (handshake && pix_last) begin
                  state_reg <= S_DONE;
                  done      <= 1'b1;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
               busy      <= 1'b0;
            end
            default: begin
               state_reg <= S_IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/conv_scan_ctrl.md
# conv_scan_ctrl

Raster-scan sequencer sitting between the 27x27 feature FWFT buffer and the 3x3 convolution datapath. On `start` it pops exactly IMG_W*IMG_H features from the FWFT. It presents each feature downstream through a registered valid/ready stage, tagged with its row/column position and a window-complete flag. It stalls on an empty buffer or downstream back-pressure, counts emitted windows, and pulses `done` when the frame has fully drained.

## Interface
- IMG_W, 27, feature-map width in pixels
- IMG_H, 27, feature-map height in pixels
- K, 3, convolution kernel size; window-complete threshold
- DATA_W, 8, feature width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- busy  out  1  high in STREAM and DONE
- done  out  1  one-cycle pulse after the last pixel handshake
- feat_valid  in  1  FWFT has data at its head
- feat_data  in  DATA_W  FWFT head data (first-word fall-through)
- feat_rd_en  out  1  pop FWFT head this cycle (combinational)
- pix_valid  out  1  output register holds a pixel
- pix_ready  in  1  downstream accepts pixel
- pix_data  out  DATA_W  pixel value
- pix_row  out  $clog2(IMG_H)  row of pix_data
- pix_col  out  $clog2(IMG_W)  column of pix_data
- win_valid  out  1  pix_row>=K-1 and pix_col>=K-1, so a full KxK window ends at this pixel
- pix_last  out  1  pixel at (IMG_H-1, IMG_W-1)
- win_count  out  $clog2((IMG_W-K+1)*(IMG_H-K+1)+1)  windows handshaken this frame

## Operation
- Reset values: state=IDLE, busy=0, done=0, feat_rd_en=0, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, win_valid=0, pix_last=0, win_count=0. Internal read counters are also 0.
- **IDLE**
  - feat_rd_en=0.
  - `start`=1 moves to STREAM, zeroes the read row/col counters and clears win_count.
- **STREAM**
  - feat_rd_en = feat_valid & (~pix_valid | pix_ready) & ~issued_all.
  - issued_all sets after IMG_W*IMG_H pops.
  - On each pop, the output register loads feat_data, the read row/col, and the derived win_valid/pix_last. The read column then increments; at IMG_W-1 it wraps to 0 and the row increments.
  - If pix_ready is high but no pop occurs, pix_valid clears.
  - If pix_valid=1 and pix_ready=0, all outputs hold unchanged.
  - A handshake with pix_last=1 moves to DONE.
- **DONE**
  - One cycle; done=1, then return to IDLE.
  - pix_valid is already 0 in DONE, because no pop follows the last pixel.
- `start` in STREAM or DONE is ignored.
- win_count increments on each handshake (pix_valid&pix_ready) where win_valid=1. It saturates at no value, since the frame bounds it to (IMG_W-K+1)*(IMG_H-K+1) = 625 by default. It holds its value in IDLE until the next `start`.
- Never pops the FWFT outside STREAM or beyond IMG_W*IMG_H pixels, even if feat_valid stays high.
- rst mid-frame: all state returns to reset values on the next edge. The FWFT is reset separately by the same rst.

## Timing
- feat_rd_en is combinational, same cycle as feat_valid; the output register is valid on the next edge. Pixel latency from FWFT head to pix_valid is 1 cycle.
- Throughput is 1 pixel/clk with pix_ready and feat_valid held high. A frame takes IMG_W*IMG_H+1 cycles from the first pop to done, so start -> done = 731 cycles with default parameters.
- Registered stage supports full-rate pipelining: a pop and a downstream handshake in the same cycle replace the register contents.
- done asserts the cycle after the pix_last handshake; busy falls the cycle after done.

## Test plan
- **Full-rate frame.** Reset, FWFT preloaded with values 0..728 mod 256, pix_ready=1, pulse start.
  - Expect 729 pixels in raster order.
  - pix_data matches the preloaded values; row/col are correct.
  - win_valid is first high at (2,2); win_count=625 at done.
  - done arrives 731 cycles after start.
- **Downstream back-pressure.** pix_ready toggles with a random 50% duty.
  - Outputs are stable while stalled; no pixel is lost or duplicated.
  - feat_rd_en is never high while pix_valid=1 and pix_ready=0.
- **Empty buffer.** feat_valid dropped for 5 cycles at pixel (10,26).
  - No pop during the gap; pix_valid clears if downstream drained.
  - Resumes at (11,0) with correct data.
- **Over-supply and start handling.** feat_valid is held high after the frame.
  - Exactly 729 pops; feat_rd_en=0 after the last pop.
  - start pulsed in STREAM is ignored; a second start after done runs a new frame with win_count cleared.
- **Mid-frame reset.** rst asserted at pixel 300.
  - All outputs take their reset values next cycle; state returns to IDLE.
  - A subsequent frame runs from (0,0).
- **Parameter variant.** IMG_W=5, IMG_H=4, K=3.
  - 20 pixels, 6 windows; win_valid only at rows 2..3, cols 2..4.
